// File: rtl/seq_detector_ctrl.sv
// Frame controller for a serial pattern detector: clears it, shifts a latched word LSB-first, then waits for its match flag.
// Optional build macro MATCH_CNT_EN adds a 4-bit wrapping count of frames that ended with hit=1.
module seq_detector_ctrl #(
  parameter int FRAME_BITS = 4,
  parameter int CHECK_WAIT = 2
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] word_in,
  input  logic                  det_match,
  output logic                  det_clr,
  output logic                  det_en,
  output logic                  det_bit,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
`ifdef MATCH_CNT_EN
  output logic [3:0]            match_cnt,
`endif
  output logic [2:0]            o_dbg_state
);

  localparam int CNT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int WAIT_W = (CHECK_WAIT > 1) ? $clog2(CHECK_WAIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(CHECK_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_hit;
  logic                  w_last_bit;
  logic                  w_wait_expired;

  assign w_last_bit     = (r_bit_cnt == LAST_BIT);
  assign w_wait_expired = (r_wait_cnt == LAST_WAIT);
  assign o_dbg_state    = r_state;
  assign hit            = r_hit;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Moore outputs: every strobe is decoded from the registered state only,
  // so det_clr, det_en and done can never overlap.
  always_comb begin
    w_next  = r_state;
    det_clr = 1'b0;
    det_en  = 1'b0;
    det_bit = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        det_clr = 1'b1;
        w_next  = S_SHIFT;
      end
      S_SHIFT: begin
        det_en  = 1'b1;
        det_bit = r_shift[0];
        if (w_last_bit) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (det_match || w_wait_expired) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_hit      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= word_in;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_shift    <= r_shift >> 1;
          r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          r_wait_cnt <= '0;
        end
        S_CHECK: begin
          if (det_match) begin
            r_hit <= 1'b1;
          end else if (w_wait_expired) begin
            r_hit <= 1'b0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MATCH_CNT_EN
  logic [3:0] r_match_cnt;

  // Counts on the CHECK->DONE transition that sets hit; 4-bit wrap is intended.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_match_cnt <= 4'd0;
    end else if (r_state == S_CHECK && det_match) begin
      r_match_cnt <= r_match_cnt + 4'd1;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_seq_detector_ctrl.sv
// Randomized bench for seq_detector_ctrl: a frame-timeline model derived from the cycle budget of each phase.
module tb_seq_detector_ctrl;

  localparam int FB = 4;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic          clk_2 = 1'b0;
  logic          reset;
  logic          start;
  logic [FB-1:0] word_in;
  logic          det_match;
  logic          det_clr, det_en, det_bit, busy, done, hit;
  logic [2:0]    o_dbg_state;
`ifdef MATCH_CNT_EN
  logic [3:0]    match_cnt;
`endif

  always #5 clk_2 = ~clk_2;

  seq_detector_ctrl #(.FRAME_BITS(FB), .CHECK_WAIT(CW)) dut (
    .clk_2       (clk_2),
    .reset       (reset),
    .start       (start),
    .word_in     (word_in),
    .det_match   (det_match),
    .det_clr     (det_clr),
    .det_en      (det_en),
    .det_bit     (det_bit),
    .busy        (busy),
    .done        (done),
    .hit         (hit),
`ifdef MATCH_CNT_EN
    .match_cnt   (match_cnt),
`endif
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic        m_hit    = 1'b0;
  int          m_cnt    = 0;
  logic [0:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, det_clr, det_en, det_bit, busy, done};
  endfunction

  task automatic check_side();
    check("hit", {31'd0, hit}, {31'd0, m_hit});
    check("dbg_busy", {31'd0, o_dbg_state != 3'd0}, {31'd0, busy});
`ifdef MATCH_CNT_EN
    check("match_cnt", {28'd0, match_cnt}, 32'(m_cnt));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_2);
      check("idle_outs", outs(), 32'd0);
      check_side();
      start     = 1'b0;
      word_in   = FB'($urandom);
      det_match = 1'(($urandom_range(0, 1)));
    end
  endtask

  // midx: CHECK cycle index at which det_match is raised (-1 = never).
  // mode: start while busy 0=low, 1=random, 2=held high. abort_c: cycle to assert reset (-1 = none).
  task automatic run_frame(input logic [FB-1:0] w, input int midx, input int mode, input int abort_c);
    int          check_len;
    int          done_c;
    logic        new_hit;
    logic [31:0] e;
    check_len = (midx >= 0) ? midx + 1 : CW;
    done_c    = FB + 2 + check_len;
    new_hit   = (midx >= 0);
    exp_q.delete();
    for (int i = 0; i < FB; i++) exp_q.push_back(w[i]);
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk_2);
      if (c == 1)                          e = 32'b10010;
      else if (c >= 2 && c <= FB + 1)      e = {27'd0, 2'b01, exp_q.pop_front(), 2'b10};
      else if (c >= FB + 2 && c < done_c)  e = 32'b00010;
      else if (c == done_c)                e = 32'b00011;
      else                                 e = 32'd0;
      if (c == done_c) begin
        m_hit = new_hit;
        if (new_hit) m_cnt = (m_cnt + 1) % 16;
      end
      check((c == 0) ? "accept_outs" : (c == 1) ? "clear_outs" : (c <= FB + 1) ? "shift_outs" :
            (c < done_c) ? "check_outs" : "done_outs", outs(), e);
      check_side();
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        m_hit = 1'b0;
        m_cnt = 0;
        check("reset_outs", outs(), 32'd0);
        check_side();
        @(negedge clk_2);
        check("reset_hold_outs", outs(), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (c == 0) begin
        start   = 1'b1;
        word_in = w;
      end else begin
        start   = (mode == 2) ? 1'b1 : (mode == 1) ? 1'(($urandom_range(0, 1))) : 1'b0;
        word_in = FB'($urandom);
      end
      if (c >= FB + 2 && c < done_c) det_match = ((c - (FB + 2)) == midx);
      else                           det_match = 1'(($urandom_range(0, 1)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    word_in   = '0;
    det_match = 1'b0;
    #1;
    check("por_outs", outs(), 32'd0);
    check_side();
    repeat (2) @(negedge clk_2);
    check("reset_outs_clk", outs(), 32'd0);
    reset = 1'b0;

    // directed: hit on first CHECK cycle, then timeout miss
    run_frame(4'b1101, 0, 0, -1);
    run_frame(4'b0110, -1, 0, -1);
    idle_cycles(2);

    // start pulses while busy must be ignored
    run_frame(4'b1010, 1, 1, -1);
    idle_cycles(3);

    // start held high: back-to-back frames, one IDLE cycle apart
    for (int f = 0; f < 4; f++)
      run_frame(FB'($urandom), int'($urandom_range(0, CW)) - 1, (f < 3) ? 2 : 0, -1);
    idle_cycles(1);

    // reset in the third SHIFT cycle
    run_frame(4'b1111, 0, 0, 4);
    idle_cycles(2);
    run_frame(4'b0011, 0, 0, -1);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      run_frame(FB'($urandom), int'($urandom_range(0, CW)) - 1, int'($urandom_range(0, 1)), -1);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
    end

    // 17 hit frames: exercises the 4-bit count wrap when present
    for (int f = 0; f < 17; f++)
      run_frame(FB'($urandom), int'($urandom_range(0, CW - 1)), 0, -1);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_ctrl.md
SEQ_DETECTOR_CTRL -- requirements
Module: seq_detector_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_BITS, default 4: number of serial bits shifted per frame.
REQ-002 The block SHALL have parameter CHECK_WAIT, default 2: maximum number of cycles spent waiting for det_match.
REQ-003 clk_2  input  1  single clock for all state, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request, level-sampled, accepted only in IDLE.
REQ-006 word_in  input  FRAME_BITS  pattern word, latched when start is accepted.
REQ-007 det_match  input  1  registered match flag from the serial pattern detector.
REQ-008 det_clr  output  1  synchronous clear strobe to the detector.
REQ-009 det_en  output  1  detector shift enable.
REQ-010 det_bit  output  1  serial data bit to the detector, valid while det_en=1.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle frame-complete pulse.
REQ-013 hit  output  1  result of the last completed frame, held until the next done.
REQ-014 match_cnt  output  4  count of frames with hit=1; present only with MATCH_CNT_EN.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, SHIFT, CHECK and DONE, all registered, with no other reachable state.
REQ-016 In IDLE with start=1, the block SHALL latch word_in into a shift register, zero the bit counter and enter CLEAR on the next edge.
REQ-017 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-018 In CLEAR, the block SHALL drive det_clr=1 for exactly one cycle and then enter SHIFT.
REQ-019 In SHIFT, the block SHALL:
- drive det_en=1 and det_bit equal to shift-register bit 0 (LSB first);
- shift right by one each cycle and increment the bit counter.
REQ-020 After exactly FRAME_BITS SHIFT cycles, the block SHALL enter CHECK.
REQ-021 In CHECK, the block SHALL drive det_en=0 and sample det_match every cycle.
REQ-022 In CHECK, if det_match=1, the block SHALL set hit=1 at the next edge and enter DONE.
REQ-023 If det_match stays 0 for CHECK_WAIT CHECK cycles, the block SHALL set hit=0 and enter DONE.
REQ-024 In DONE, the block SHALL drive done=1 for one cycle and then enter IDLE unconditionally.
REQ-025 Latency: with start accepted at edge T, det_clr SHALL be high in cycle T+1 and det_en high in cycles T+2..T+1+FRAME_BITS; the earliest done SHALL be at cycle T+3+FRAME_BITS.
REQ-026 start while busy=1 SHALL be ignored, not queued; start held high SHALL start a new frame from the IDLE cycle following DONE, so at least one IDLE cycle separates frames.
REQ-027 det_match outside CHECK SHALL be ignored and SHALL NOT affect hit.
REQ-028 det_clr, det_en and done SHALL be mutually exclusive in every cycle.
REQ-029 word_in changes after acceptance SHALL NOT alter the frame in progress.

Reset
REQ-030 While reset=1, the block SHALL, independent of clk_2:
- force IDLE;
- drive det_clr=0, det_en=0, det_bit=0, busy=0, done=0 and hit=0;
- clear the shift register and bit counter, and set match_cnt=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame without a done pulse and without changing match_cnt after release.
REQ-032 After reset deasserts, the first start SHALL be accepted on the first rising edge on which start=1.

Configuration
REQ-033 With macro MATCH_CNT_EN defined, match_cnt SHALL increment by 1 on each transition into DONE with hit=1 and SHALL wrap 15->0.
REQ-034 Without MATCH_CNT_EN, the match_cnt port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset, then word_in=4'b1101 and a one-cycle start with det_match pulsed in the first CHECK cycle -> det_bit sequence 1,0,1,1; done one cycle later; hit=1; match_cnt=1.
REQ-036 word_in=4'b0110 with det_match held 0 -> exactly 2 CHECK cycles, then done=1 with hit=0; match_cnt unchanged.
REQ-037 Pulse start three times during SHIFT -> no extra frame; exactly one done pulse.
REQ-038 Hold start=1 for 40 cycles -> frames back-to-back with exactly one IDLE cycle between each DONE and the next CLEAR.
REQ-039 Assert reset in the third SHIFT cycle -> all outputs 0 immediately, no done pulse, IDLE after release.
REQ-040 With MATCH_CNT_EN, complete 17 hit frames -> match_cnt=1 after wrap.
